stream_fifo: RTL

Synchronous first-word-fall-through FIFO with valid/ready on both sides. Sits between the traffic generator and the custom logic stage, absorbing bursts and generator/consumer stalls (DELAY settings) without dropping or duplicating words. Breaks the ready path: `up_ready` never depends combinationally on `down_ready`. Also reports live occupancy and a high-water mark for the bench.

---
 rtl/stream_fifo.sv | 81 ++++++++
 1 files changed

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides.
// up_ready is decoded from the registered count only, so it never depends on down_ready.
module stream_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_valid,
    input  logic [DW-1:0]            up_data,
    output logic                     up_ready,
    output logic                     down_valid,
    output logic [DW-1:0]            down_data,
    input  logic                     down_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   max_count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   max_q, max_d;
    logic          push, pop;

    always_comb begin
        up_ready   = !rst && (count_q != FULL);
        down_valid = !rst && (count_q != '0);
        down_data  = mem_q[rp_q];
        push       = up_valid && up_ready;
        pop        = down_valid && down_ready;

        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;

        if (push) begin
            mem_d[wp_q] = up_data;
            wp_d        = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end

        // High-water mark tracks the occupancy the FIFO is about to hold.
        max_d = (count_d > max_q) ? count_d : max_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            max_q   <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            max_q   <= max_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count     = count_q;
    assign max_count = max_q;

endmodule
